touch_irq_sequencer: RTL

Autonomous service sequencer for the LCD touch-interrupt PIO on the MTL2 panel path. Acts as the single Avalon-MM master of that PIO: arms its IRQ mask after reset, detects its IRQ, reads and clears the edge-capture register, and runs a request/done handshake with the downstream touch-data fetch engine (I2C reader). It then raises one coalesced, rate-limited event interrupt toward the HPS, so software never touches the PIO directly.

---
 rtl/touch_irq_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/touch_irq_sequencer.sv
// Touch PIO service sequencer: arms the PIO mask, reads and clears edge-capture, and
// handshakes with the fetch engine. Define TOUCH_IRQ_SEQ_HOLDOFF_EN to get the post-fetch holdoff.
module touch_irq_sequencer #(
    parameter int CNT_W          = 16,
    parameter int HOLDOFF_CYCLES = 50000,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              pio_irq,
    output logic [1:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata,
    output logic              fetch_req,
    input  logic              fetch_done,
    output logic              evt_irq,
    input  logic              evt_ack,
    output logic [CNT_W-1:0]  evt_count,
    output logic              timeout_err,
    output logic              busy
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        INIT_MASK, IDLE, RD_EC, RD_WAIT, CLR_EC, FETCH, HOLDOFF
    } state_t;

    state_t          state;
    logic            started;
    logic [TO_W-1:0] to_cnt;
`ifdef TOUCH_IRQ_SEQ_HOLDOFF_EN
    localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);
    logic [HO_W-1:0] ho_cnt;
`endif

    // Bus outputs are registered decodes of the state being entered; with registered
    // outputs, INIT_MASK spans the reset period plus the cycle that shows the mask write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= INIT_MASK;
            started      <= 1'b0;
            to_cnt       <= '0;
`ifdef TOUCH_IRQ_SEQ_HOLDOFF_EN
            ho_cnt       <= '0;
`endif
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= 2'd0;
            m_writedata  <= 32'd0;
            fetch_req    <= 1'b0;
            evt_irq      <= 1'b0;
            evt_count    <= '0;
            timeout_err  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= 2'd0;
            m_writedata  <= 32'd0;
            if (evt_ack) begin
                evt_irq     <= 1'b0;
                timeout_err <= 1'b0;
            end

            case (state)
                INIT_MASK: begin
                    if (!started) begin
                        started      <= 1'b1;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_address    <= 2'd2;
                        m_writedata  <= 32'd1;
                        busy         <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (enable && pio_irq) begin
                        state        <= RD_EC;
                        busy         <= 1'b1;
                        m_chipselect <= 1'b1;
                        m_address    <= 2'd3;
                    end
                end
                RD_EC: state <= RD_WAIT;
                RD_WAIT: begin
                    if (m_readdata[0]) begin
                        state        <= CLR_EC;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_address    <= 2'd3;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                CLR_EC: begin
                    state     <= FETCH;
                    fetch_req <= 1'b1;
                    to_cnt    <= '0;
                end
                FETCH: begin
                    // done is checked first so it wins over a coincident timeout
                    if (fetch_done) begin
                        fetch_req <= 1'b0;
                        evt_count <= evt_count + CNT_W'(1);
                        evt_irq   <= 1'b1;
`ifdef TOUCH_IRQ_SEQ_HOLDOFF_EN
                        state     <= HOLDOFF;
                        ho_cnt    <= '0;
`else
                        state     <= IDLE;
                        busy      <= 1'b0;
`endif
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        fetch_req   <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                HOLDOFF: begin
`ifdef TOUCH_IRQ_SEQ_HOLDOFF_EN
                    if (ho_cnt == HO_W'(HOLDOFF_CYCLES - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ho_cnt <= ho_cnt + HO_W'(1);
                    end
`else
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
